execute_muldiv: RTL and testbench
=================================

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32, 64.
REQ-002 Parameter MD_CNT_W, default $clog2(XLEN)+1: iteration counter width.
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 JumpE, BranchE, ALUSrcE  in  1 each: control, same meaning as the base execute stage.
REQ-006 ForwardAE, ForwardBE  in  2 each: operand select; 00 register, 01 ResultW, 10 ALUResultM, 11 zero.
REQ-007 ALUControlE  in  4: ALU opcode.
REQ-008 MulDivE  in  1: instruction in E is an M-extension op.
REQ-009 MulDivOpE  in  3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 order).
REQ-010 StallE, FlushE  in  1 each: hazard-unit hold and kill of the E register.
REQ-011 PCE, ExtImmE, RD1E, RD2E, ALUResultM, ResultW  in  XLEN each: operands and forwarded data.
REQ-012 ALUResultE, WriteDataE, PCTargetE  out  XLEN each: result, forwarded rs2, branch target.
REQ-013 PCSrcE  out  1: redirect = (ZeroE and BranchE) or JumpE.
REQ-014 BusyE  out  1: M-op in progress; hazard unit stalls F/D/E and bubbles M while high.

Function
REQ-015 SrcAE/WriteDataE mux, ALUSrcE mux, ALU, PCSrcE and PCTargetE = PCE + ExtImmE (mod 2^XLEN) shall behave as the base execute stage, combinationally.
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE: BusyE = MulDivE and not FlushE (combinational); on that condition capture SrcAE, WriteDataE (never ExtImmE), op; go RUN, counter = 0.
REQ-018 IDLE start with DIV/DIVU/REM/REMU and divisor 0, or DIV/REM with dividend = most-negative and divisor = -1: go directly to DONE, result per REQ-021.
REQ-019 RUN: one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle; BusyE = 1; after exactly XLEN steps go DONE.
REQ-020 DONE: BusyE = 0; ALUResultE = M-op result; next state IDLE unless StallE = 1, then hold DONE with result stable.
REQ-021 Special results: divide-by-zero -> quotient all ones, remainder = dividend; overflow -> quotient = most-negative, remainder 0.
REQ-022 Signed ops: operate on magnitudes, fix sign at DONE; MULH/MULHSU/MULHU return upper XLEN bits of the 2*XLEN product, MUL the lower.
REQ-023 Total latency, start to result: XLEN+1 cycles normal, 1 cycle special case; BusyE high exactly XLEN cycles normal, 0 extra cycles special.
REQ-024 MulDivE = 0 in IDLE: ALUResultE = ALU result; FSM inert.
REQ-025 FlushE = 1 in any state: next state IDLE, result discarded; FlushE has priority over StallE.
REQ-026 PCSrcE = 0 whenever the FSM is not in IDLE.

Reset
REQ-027 reset = 1: state IDLE, counter 0, operand/accumulator registers 0, BusyE 0 next cycle; reset mid-RUN aborts with no result.

Structure
REQ-028 Package execute_pkg shall hold muldiv_op_t, md_state_t, forward-select encodings, XLEN default.
REQ-029 Iterative engine shall be sub-module muldiv_iter (start, op, a, b -> busy, done, result); execute_muldiv holds muxes, ALU instance and control glue.

Verification
REQ-030 MUL 7 x -3, XLEN=32 -> BusyE high 32 cycles, then ALUResultE = 0xFFFFFFEB for one cycle.
REQ-031 DIVU 100 / 0 -> no RUN; next cycle DONE, ALUResultE = 0xFFFFFFFF; REMU 100 / 0 -> 100.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0, both 1-cycle latency.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 2 -> 0xFFFFFFFF.
REQ-034 DIV -7 / 2 forwarded via ForwardAE = 10, FlushE pulsed at RUN cycle 10 -> IDLE next cycle, BusyE low; retry -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-035 StallE held 3 cycles in DONE -> ALUResultE stable 4 cycles; reset asserted mid-RUN -> IDLE, BusyE 0.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared types and encodings for the execute stage and its iterative M-extension unit.
package execute_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
        MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE, MD_RUN, MD_DONE
    } md_state_t;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_RESW = 2'b01;
    localparam logic [1:0] FWD_ALUM = 2'b10;
    localparam logic [1:0] FWD_ZERO = 2'b11;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    function automatic logic md_is_div(input muldiv_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_a_signed(input muldiv_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_b_signed(input muldiv_op_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/execute_alu.sv
// Base execute-stage ALU: combinational, zero flag feeds branch resolution.
module execute_alu
    import execute_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply / restoring divide. Works on magnitudes; sign is applied
// combinationally while the result is presented in DONE.
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MD_CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic            hold,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic            idle,
    output logic [XLEN-1:0] result
);
    localparam logic [MD_CNT_W-1:0] LAST    = MD_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]     MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t             state, state_nx;
    logic [MD_CNT_W-1:0]   cnt;
    muldiv_op_t            op_q;
    logic [XLEN-1:0]       hi, lo, bm;
    logic                  neg_q, neg_r;

    logic                  a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic [XLEN:0]         mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0]     prod, prod_fix;

    assign a_neg = md_a_signed(op) & a[XLEN-1];
    assign b_neg = md_b_signed(op) & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign div0  = md_is_div(op) & (b == '0);
    assign ovf   = (op == MD_DIV || op == MD_REM) && (a == MIN_NEG) && (b == '1);

    // hi:lo is the product while multiplying, remainder:quotient while dividing
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, bm} : '0);
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, bm};

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            MD_IDLE: begin
                busy = start;
                if (start) state_nx = (div0 || ovf) ? MD_DONE : MD_RUN;
            end
            MD_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nx = MD_DONE;
            end
            MD_DONE: if (!hold) state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
        if (flush) state_nx = MD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            op_q  <= MD_MUL;
            hi    <= '0;
            lo    <= '0;
            bm    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                MD_IDLE: if (start) begin
                    op_q <= op;
                    cnt  <= '0;
                    bm   <= b_mag;
                    if (div0) begin
                        hi    <= a;
                        lo    <= '1;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (ovf) begin
                        hi    <= '0;
                        lo    <= MIN_NEG;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else begin
                        hi    <= '0;
                        lo    <= a_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                    end
                end
                MD_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (md_is_div(op_q)) begin
                        hi <= div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], ~div_diff[XLEN]};
                    end else begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign prod     = {hi, lo};
    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        result = lo;
        case (op_q)
            MD_MUL:                       result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = neg_q ? -lo : lo;
            default:                      result = neg_r ? -hi : hi;
        endcase
    end

    assign done = (state == MD_DONE);
    assign idle = (state == MD_IDLE);
endmodule

// File: rtl/execute_muldiv.sv
// Execute stage with forwarding muxes, ALU, branch target and an iterative M-extension unit
// that holds the pipeline via BusyE and presents its result on ALUResultE in DONE.
module execute_muldiv
    import execute_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MD_CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [3:0]      ALUControlE,
    input  logic            MulDivE,
    input  logic [2:0]      MulDivOpE,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ExtImmE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            BusyE
);
    logic [XLEN-1:0] SrcAE, SrcBE, AluRawE, MdResultE;
    logic            ZeroE, MdDoneE, MdIdleE;

    always_comb begin
        case (ForwardAE)
            FWD_REG:  SrcAE = RD1E;
            FWD_RESW: SrcAE = ResultW;
            FWD_ALUM: SrcAE = ALUResultM;
            default:  SrcAE = '0;
        endcase
        case (ForwardBE)
            FWD_REG:  WriteDataE = RD2E;
            FWD_RESW: WriteDataE = ResultW;
            FWD_ALUM: WriteDataE = ALUResultM;
            default:  WriteDataE = '0;
        endcase
    end

    assign SrcBE     = ALUSrcE ? ExtImmE : WriteDataE;
    assign PCTargetE = PCE + ExtImmE;

    execute_alu #(.XLEN(XLEN)) u_alu (
        .a      (SrcAE),
        .b      (SrcBE),
        .ctrl   (ALUControlE),
        .result (AluRawE),
        .zero   (ZeroE)
    );

    // The M unit always takes rs2 from the forwarded register value, never the immediate
    muldiv_iter #(.XLEN(XLEN), .MD_CNT_W(MD_CNT_W)) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (MulDivE & ~FlushE),
        .flush  (FlushE),
        .hold   (StallE),
        .op     (muldiv_op_t'(MulDivOpE)),
        .a      (SrcAE),
        .b      (WriteDataE),
        .busy   (BusyE),
        .done   (MdDoneE),
        .idle   (MdIdleE),
        .result (MdResultE)
    );

    assign ALUResultE = MdDoneE ? MdResultE : AluRawE;
    assign PCSrcE     = MdIdleE & ((ZeroE & BranchE) | JumpE);
endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized and directed bench for execute_muldiv against an arithmetic reference model.
module tb_execute_muldiv;
    import execute_pkg::*;

    logic        clk, reset, JumpE, BranchE, ALUSrcE, MulDivE, StallE, FlushE, PCSrcE, BusyE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [3:0]  ALUControlE;
    logic [2:0]  MulDivOpE;
    logic [31:0] PCE, ExtImmE, RD1E, RD2E, ALUResultM, ResultW;
    logic [31:0] ALUResultE, WriteDataE, PCTargetE;

    int          n_checks, n_errors, nb;
    logic [31:0] res, ea, eb, eb0, eexp, ra, rb;
    logic [2:0]  rop;
    logic        spec_case;

    execute_muldiv #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUControlE(ALUControlE),
        .MulDivE(MulDivE), .MulDivOpE(MulDivOpE), .StallE(StallE), .FlushE(FlushE),
        .PCE(PCE), .ExtImmE(ExtImmE), .RD1E(RD1E), .RD2E(RD2E), .ALUResultM(ALUResultM),
        .ResultW(ResultW), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .BusyE(BusyE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << b[4:0];
            4'd8: return a >> b[4:0];
            4'd9: return 32'(signed'(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] r);
        case (sel)
            2'b00: return r;
            2'b01: return ResultW;
            2'b10: return ALUResultM;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op >= 3'd4 && b == 0) ||
               ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one M-op, count RUN-phase busy cycles, return sampled in the first non-busy cycle
    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fa, output logic [31:0] r, output int nbusy);
        @(posedge clk); #1;
        MulDivE = 1'b1; MulDivOpE = op; ForwardAE = fa; ForwardBE = FWD_REG;
        ALUSrcE = 1'b1; ExtImmE = $urandom; RD2E = b;
        if (fa == FWD_ALUM) begin ALUResultM = a; RD1E = $urandom; end
        else RD1E = a;
        @(negedge clk);
        check("busy_start", {31'b0, BusyE}, 32'd1);
        nbusy = 0;
        @(negedge clk);
        while (BusyE && nbusy < 100) begin
            nbusy++;
            @(negedge clk);
        end
        r = ALUResultE;
        JumpE = 1'b1; #1;
        check("pcsrc_done", {31'b0, PCSrcE}, 32'd0);
        JumpE = 1'b0;
    endtask

    task automatic retire();
        @(posedge clk); #1;
        MulDivE = 1'b0; ALUSrcE = 1'b0; ALUControlE = ALU_ADD;
        ForwardAE = FWD_REG; ForwardBE = FWD_REG;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b1; JumpE = 0; BranchE = 0; ALUSrcE = 0; MulDivE = 0; StallE = 0; FlushE = 0;
        ForwardAE = 0; ForwardBE = 0; ALUControlE = 0; MulDivOpE = 0;
        PCE = 0; ExtImmE = 0; RD1E = 0; RD2E = 0; ALUResultM = 0; ResultW = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, BusyE}, 32'd0);
        check("rst_alu", ALUResultE, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Plain ALU behaviour with MulDivE low
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            ALUControlE = 4'($urandom_range(0, 9));
            ALUSrcE = 1'($urandom_range(0, 1));
            ForwardAE = 2'($urandom_range(0, 3));
            ForwardBE = 2'($urandom_range(0, 3));
            RD1E = $urandom; RD2E = $urandom; ExtImmE = $urandom; PCE = $urandom;
            ALUResultM = $urandom; ResultW = $urandom;
            BranchE = 1'($urandom_range(0, 1)); JumpE = 1'($urandom_range(0, 1));
            if (i % 4 == 0) begin
                ALUControlE = ALU_SUB; ForwardAE = FWD_REG; ForwardBE = FWD_REG;
                ALUSrcE = 1'b0; RD2E = RD1E; BranchE = 1'b1; JumpE = 1'b0;
            end
            ea = fwd_ref(ForwardAE, RD1E);
            eb0 = fwd_ref(ForwardBE, RD2E);
            eb = ALUSrcE ? ExtImmE : eb0;
            eexp = alu_ref(ALUControlE, ea, eb);
            @(negedge clk);
            check("alu_res", ALUResultE, eexp);
            check("alu_wdata", WriteDataE, eb0);
            check("alu_pctarget", PCTargetE, PCE + ExtImmE);
            check("alu_pcsrc", {31'b0, PCSrcE}, {31'b0, ((eexp == 0) && BranchE) || JumpE});
        end
        @(posedge clk); #1 BranchE = 1'b0; JumpE = 1'b0;

        // MUL 7 x -3: 32 busy cycles, result for exactly one cycle
        do_md(3'd0, 32'd7, 32'hFFFF_FFFD, FWD_REG, res, nb);
        check("mul_res", res, 32'hFFFF_FFEB);
        check("mul_busy", nb, 32'd32);
        retire();
        @(negedge clk);
        check("mul_after", ALUResultE, 32'd4);
        check("mul_after_busy", {31'b0, BusyE}, 32'd0);

        do_md(3'd5, 32'd100, 32'd0, FWD_REG, res, nb); retire();
        check("divu0_res", res, 32'hFFFF_FFFF);
        check("divu0_busy", nb, 32'd0);
        do_md(3'd7, 32'd100, 32'd0, FWD_REG, res, nb); retire();
        check("remu0_res", res, 32'd100);
        check("remu0_busy", nb, 32'd0);
        do_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, FWD_REG, res, nb); retire();
        check("div_ovf_res", res, 32'h8000_0000);
        check("div_ovf_busy", nb, 32'd0);
        do_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, FWD_REG, res, nb); retire();
        check("rem_ovf_res", res, 32'd0);
        check("rem_ovf_busy", nb, 32'd0);
        do_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FWD_REG, res, nb); retire();
        check("mulhu_res", res, 32'hFFFF_FFFE);
        do_md(3'd2, 32'hFFFF_FFFF, 32'd2, FWD_REG, res, nb); retire();
        check("mulhsu_res", res, 32'hFFFF_FFFF);

        // DIV -7 / 2 forwarded from M, killed at RUN cycle 10, then retried
        @(posedge clk); #1;
        MulDivE = 1'b1; MulDivOpE = 3'd4; ForwardAE = FWD_ALUM; ForwardBE = FWD_REG;
        ALUResultM = 32'hFFFF_FFF9; RD1E = $urandom; RD2E = 32'd2; ALUSrcE = 1'b0; ALUControlE = ALU_ADD;
        repeat (10) @(posedge clk);
        #1 FlushE = 1'b1;
        @(negedge clk);
        check("flush_run_busy", {31'b0, BusyE}, 32'd1);
        @(posedge clk); #1 FlushE = 1'b0; MulDivE = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'b0, BusyE}, 32'd0);
        check("flush_alu", ALUResultE, 32'hFFFF_FFFB);
        do_md(3'd4, 32'hFFFF_FFF9, 32'd2, FWD_ALUM, res, nb); retire();
        check("div_retry_res", res, 32'hFFFF_FFFD);
        check("div_retry_busy", nb, 32'd32);
        do_md(3'd6, 32'hFFFF_FFF9, 32'd2, FWD_ALUM, res, nb); retire();
        check("rem_retry_res", res, 32'hFFFF_FFFF);

        // StallE held for 3 cycles in DONE keeps the result for 4 cycles
        do_md(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, FWD_REG, res, nb);
        check("stall_res0", res, md_ref(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
        StallE = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_hold_%0d", i), ALUResultE, res);
            check($sformatf("stall_busy_%0d", i), {31'b0, BusyE}, 32'd0);
            if (i == 3) StallE = 1'b0;
        end
        retire();
        @(negedge clk);
        check("stall_after", ALUResultE, 32'h1234_5678 + 32'h9ABC_DEF0);

        // FlushE wins over StallE in DONE
        do_md(3'd0, 32'd9, 32'd9, FWD_REG, res, nb);
        check("sf_res", res, 32'd81);
        StallE = 1'b1; FlushE = 1'b1;
        retire();
        StallE = 1'b0; FlushE = 1'b0;
        @(negedge clk);
        check("sf_after", ALUResultE, 32'd18);

        // Reset in the middle of RUN aborts
        @(posedge clk); #1;
        MulDivE = 1'b1; MulDivOpE = 3'd0; RD1E = 32'd11; RD2E = 32'd13; ALUSrcE = 1'b0;
        ForwardAE = FWD_REG; ForwardBE = FWD_REG;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; MulDivE = 1'b0;
        @(negedge clk);
        check("rstrun_busy", {31'b0, BusyE}, 32'd0);
        check("rstrun_alu", ALUResultE, 32'd24);

        // Randomized M-ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin
                    ra = $urandom_range(0, 20); rb = $urandom_range(1, 7);
                    if ($urandom_range(0, 1) == 1) ra = -ra;
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                default: ;
            endcase
            spec_case = is_special(rop, ra, rb);
            do_md(rop, ra, rb, ($urandom_range(0, 1) == 1) ? FWD_ALUM : FWD_REG, res, nb);
            retire();
            check($sformatf("rand_%0d_op%0d_res", i, rop), res, md_ref(rop, ra, rb));
            check($sformatf("rand_%0d_op%0d_busy", i, rop), nb, spec_case ? 32'd0 : 32'd32);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
